// File: rtl/nios2_cordic_sysid_checker.sv
// Boot-time system-ID checker: reads the ID word (addr 0) and the timestamp word (addr 1)
// over Avalon-MM, compares both against build-time values, and exposes registered pass/fail flags.
module nios2_cordic_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1458155051,
  parameter int          READ_LATENCY = 0,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        mismatch,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, CMP} state_t;

  localparam bit         ZERO_LAT = (READ_LATENCY == 0);
  localparam logic [1:0] LAT_LOAD = ZERO_LAT ? 2'd0 : 2'(READ_LATENCY - 1);

  state_t      state, nxt;
  logic [1:0]  lat_cnt, lat_cnt_d;
  logic        auto_pend;
  logic        id_match, id_match_d;
  logic        cap_id, cap_ts;
  logic        m_read_d, m_address_d, busy_d, done_d;
  logic        id_ok_d, ts_ok_d, mismatch_d;
  logic [31:0] captured_id_d, captured_ts_d;

  // State and every output are registered together so outputs follow the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      lat_cnt     <= 2'd0;
      auto_pend   <= AUTO_START;
      id_match    <= 1'b0;
      m_read      <= 1'b0;
      m_address   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      mismatch    <= 1'b0;
      captured_id <= 32'd0;
      captured_ts <= 32'd0;
    end else begin
      state       <= nxt;
      lat_cnt     <= lat_cnt_d;
      auto_pend   <= 1'b0;
      id_match    <= id_match_d;
      m_read      <= m_read_d;
      m_address   <= m_address_d;
      busy        <= busy_d;
      done        <= done_d;
      id_ok       <= id_ok_d;
      ts_ok       <= ts_ok_d;
      mismatch    <= mismatch_d;
      captured_id <= captured_id_d;
      captured_ts <= captured_ts_d;
    end
  end

  always_comb begin
    nxt       = state;
    lat_cnt_d = lat_cnt;
    cap_id    = 1'b0;
    cap_ts    = 1'b0;
    case (state)
      IDLE:   if (start || auto_pend) nxt = RD_ID;
      RD_ID:  if (!m_waitrequest) begin
                if (ZERO_LAT) begin
                  cap_id = 1'b1;
                  nxt    = RD_TS;
                end else begin
                  nxt       = LAT_ID;
                  lat_cnt_d = LAT_LOAD;
                end
              end
      LAT_ID: if (lat_cnt == 2'd0) begin
                cap_id = 1'b1;
                nxt    = RD_TS;
              end else lat_cnt_d = lat_cnt - 2'd1;
      RD_TS:  if (!m_waitrequest) begin
                if (ZERO_LAT) begin
                  cap_ts = 1'b1;
                  nxt    = CMP;
                end else begin
                  nxt       = LAT_TS;
                  lat_cnt_d = LAT_LOAD;
                end
              end
      LAT_TS: if (lat_cnt == 2'd0) begin
                cap_ts = 1'b1;
                nxt    = CMP;
              end else lat_cnt_d = lat_cnt - 2'd1;
      CMP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // The ID match is held privately so both flags become visible together with done.
  always_comb begin
    m_read_d      = (nxt == RD_ID) || (nxt == RD_TS);
    m_address_d   = (nxt == RD_TS);
    busy_d        = (nxt != IDLE);
    done_d        = (nxt == CMP);
    id_match_d    = id_match;
    id_ok_d       = id_ok;
    ts_ok_d       = ts_ok;
    mismatch_d    = mismatch;
    captured_id_d = captured_id;
    captured_ts_d = captured_ts;
    if (state == IDLE && nxt == RD_ID) begin
      id_ok_d    = 1'b0;
      ts_ok_d    = 1'b0;
      mismatch_d = 1'b0;
    end
    if (cap_id) begin
      captured_id_d = m_readdata;
      id_match_d    = (m_readdata == EXPECTED_ID);
    end
    if (cap_ts) begin
      captured_ts_d = m_readdata;
      id_ok_d       = id_match;
      ts_ok_d       = (m_readdata == EXPECTED_TS);
      mismatch_d    = !(id_match && (m_readdata == EXPECTED_TS));
    end
  end

endmodule

// File: tb/tb_nios2_cordic_sysid_checker.sv
// Bench for the system-ID checker: a zero-latency DUT with a stallable slave and a
// latency-2 DUT with a delayed-data slave, both checked against a cycle-count/flag model.
module tb_nios2_cordic_sysid_checker;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1458155051;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // DUT 0: READ_LATENCY 0, combinational slave
  logic        start0 = 1'b0, wr0 = 1'b0;
  logic        m_address0, m_read0, busy0, done0, id_ok0, ts_ok0, mis0;
  logic [31:0] rdata0, cid0, cts0;
  logic [31:0] id0_val = EXP_ID, ts0_val = EXP_TS;
  assign rdata0 = m_address0 ? ts0_val : id0_val;

  // DUT 1: READ_LATENCY 2, data valid only two cycles after accept
  logic        start2 = 1'b0;
  logic        wr2;
  logic        m_address2, m_read2, busy2, done2, id_ok2, ts_ok2, mis2;
  logic [31:0] rdata2, cid2, cts2;
  logic [31:0] id2_val = EXP_ID, ts2_val = EXP_TS;
  logic        p1v, p1a, p2v, p2a;
  assign wr2 = 1'b0;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p1v <= 1'b0; p1a <= 1'b0; p2v <= 1'b0; p2a <= 1'b0;
    end else begin
      p1v <= m_read2 & ~wr2; p1a <= m_address2; p2v <= p1v; p2a <= p1a;
    end
  end
  assign rdata2 = p2v ? (p2a ? ts2_val : id2_val) : 32'hxxxx_xxxx;

  nios2_cordic_sysid_checker u0 (
    .clock(clock), .reset_n(reset_n), .start(start0), .m_address(m_address0), .m_read(m_read0),
    .m_waitrequest(wr0), .m_readdata(rdata0), .busy(busy0), .done(done0), .id_ok(id_ok0),
    .ts_ok(ts_ok0), .mismatch(mis0), .captured_id(cid0), .captured_ts(cts0));

  nios2_cordic_sysid_checker #(.READ_LATENCY(2)) u2 (
    .clock(clock), .reset_n(reset_n), .start(start2), .m_address(m_address2), .m_read(m_read2),
    .m_waitrequest(wr2), .m_readdata(rdata2), .busy(busy2), .done(done2), .id_ok(id_ok2),
    .ts_ok(ts_ok2), .mismatch(mis2), .captured_id(cid2), .captured_ts(cts2));

  // Waitrequest generator for DUT 0: mode 1 stalls the timestamp read 4 times, mode 2 is random.
  int wr_mode = 0;
  int stall_base = 0;
  int stall_cnt0 = 0;
  always @(negedge clock) begin
    if (m_read0 && ((wr_mode == 1 && m_address0 && (stall_cnt0 - stall_base) < 4) ||
                    (wr_mode == 2 && $urandom_range(0, 3) == 0))) begin
      wr0 <= 1'b1;
      stall_cnt0 <= stall_cnt0 + 1;
    end else wr0 <= 1'b0;
  end

  task automatic pulse_start(input int which);
    @(posedge clock); #1;
    if (which == 2) start2 = 1'b1; else start0 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0; start2 = 1'b0;
  endtask

  // Observes from the current sample onward until done; len counts first m_read cycle to done inclusive.
  task automatic run_to_done(input int which, output int len, output int ts_rd, output bit to);
    int first = -1;
    logic rd, ad, dn;
    len = 0; ts_rd = 0; to = 1'b1;
    for (int k = 0; k < 80; k++) begin
      if (k > 0) begin @(posedge clock); #1; end
      rd = (which == 2) ? m_read2 : m_read0;
      ad = (which == 2) ? m_address2 : m_address0;
      dn = (which == 2) ? done2 : done0;
      if (rd && first < 0) first = k;
      if (rd && ad) ts_rd++;
      if (dn) begin len = k - first + 1; to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if ({m_read0, m_address0, busy0, done0, id_ok0, ts_ok0, mis0, cid0, cts0} !== '0) begin
      n_err++; $display("FAIL reset_u0: got %h want 0", {m_read0, m_address0, busy0, done0, id_ok0, ts_ok0, mis0, cid0, cts0}); end
    n_cmp++; if ({m_read2, m_address2, busy2, done2, id_ok2, ts_ok2, mis2, cid2, cts2} !== '0) begin
      n_err++; $display("FAIL reset_u2: got %h want 0", {m_read2, m_address2, busy2, done2, id_ok2, ts_ok2, mis2, cid2, cts2}); end
  endtask

  task automatic test_auto_start();
    int len, tsr; bit to;
    @(negedge clock); reset_n = 1'b1; #1;
    n_cmp++; if (m_read0 !== 1'b0) begin n_err++; $display("FAIL auto_mread_c0: got %b want 0", m_read0); end
    @(posedge clock); #1;
    n_cmp++; if (m_read0 !== 1'b1) begin n_err++; $display("FAIL auto_mread_c1: got %b want 1", m_read0); end
    run_to_done(0, len, tsr, to);
    n_cmp++; if (to || len != 3) begin n_err++; $display("FAIL auto_len: got %0d (timeout %0d) want 3", len, to); end
    n_cmp++; if ({id_ok0, ts_ok0, mis0} !== 3'b110) begin n_err++; $display("FAIL auto_flags: got %b want 110", {id_ok0, ts_ok0, mis0}); end
    n_cmp++; if (cts0 !== EXP_TS) begin n_err++; $display("FAIL auto_cts: got %0d want %0d", cts0, EXP_TS); end
    repeat (10) @(posedge clock);
  endtask

  task automatic test_mismatch_id();
    int len, tsr; bit to;
    id0_val = 32'd1; ts0_val = EXP_TS;
    pulse_start(0);
    n_cmp++; if (m_read0 !== 1'b1) begin n_err++; $display("FAIL start_mread: got %b want 1", m_read0); end
    n_cmp++; if (id_ok0 !== 1'b0) begin n_err++; $display("FAIL flags_cleared: got %b want 0", id_ok0); end
    run_to_done(0, len, tsr, to);
    n_cmp++; if (to || len != 3) begin n_err++; $display("FAIL mis_len: got %0d want 3", len); end
    n_cmp++; if ({id_ok0, ts_ok0, mis0} !== 3'b011) begin n_err++; $display("FAIL mis_flags: got %b want 011", {id_ok0, ts_ok0, mis0}); end
    n_cmp++; if (cid0 !== 32'd1) begin n_err++; $display("FAIL mis_cid: got %0h want 1", cid0); end
    id0_val = EXP_ID;
  endtask

  task automatic test_stall();
    int len, tsr, stalls; bit to;
    stall_base = stall_cnt0; wr_mode = 1;
    pulse_start(0);
    run_to_done(0, len, tsr, to);
    stalls = stall_cnt0 - stall_base;
    wr_mode = 0;
    n_cmp++; if (stalls != 4) begin n_err++; $display("FAIL stall_count: got %0d want 4", stalls); end
    n_cmp++; if (to || len != 3 + 4) begin n_err++; $display("FAIL stall_len: got %0d want 7", len); end
    n_cmp++; if (tsr != 5) begin n_err++; $display("FAIL stall_hold: got %0d want 5", tsr); end
    n_cmp++; if ({id_ok0, ts_ok0, mis0} !== 3'b110) begin n_err++; $display("FAIL stall_flags: got %b want 110", {id_ok0, ts_ok0, mis0}); end
  endtask

  task automatic test_latency2();
    int len, tsr; bit to;
    for (int i = 0; i < 4; i++) begin
      id2_val = (i == 0 || i == 2) ? EXP_ID : $urandom;
      ts2_val = (i == 0 || i == 3) ? EXP_TS : $urandom;
      pulse_start(2);
      run_to_done(2, len, tsr, to);
      n_cmp++; if (to || len != 7) begin n_err++; $display("FAIL lat2_len[%0d]: got %0d want 7", i, len); end
      n_cmp++; if (cid2 !== id2_val || cts2 !== ts2_val) begin
        n_err++; $display("FAIL lat2_cap[%0d]: got %h/%h want %h/%h", i, cid2, cts2, id2_val, ts2_val); end
      n_cmp++; if ({id_ok2, ts_ok2, mis2} !== {id2_val == EXP_ID, ts2_val == EXP_TS, !(id2_val == EXP_ID && ts2_val == EXP_TS)}) begin
        n_err++; $display("FAIL lat2_flags[%0d]: got %b", i, {id_ok2, ts_ok2, mis2}); end
    end
    id2_val = EXP_ID; ts2_val = EXP_TS;
  endtask

  task automatic test_start_ignored();
    int dones = 0, late_reads = 0;
    bit seen = 1'b0;
    pulse_start(0);
    for (int k = 0; k < 15; k++) begin
      if (done0) dones++;
      if (seen && m_read0) late_reads++;
      start0 = (k == 1) || (done0 && !seen);
      if (done0) seen = 1'b1;
      @(posedge clock); #1;
    end
    start0 = 1'b0;
    n_cmp++; if (dones != 1) begin n_err++; $display("FAIL ignore_dones: got %0d want 1", dones); end
    n_cmp++; if (late_reads != 0) begin n_err++; $display("FAIL ignore_reads: got %0d want 0", late_reads); end
  endtask

  task automatic test_reset_mid();
    int len, tsr; bit to;
    bit hit = 1'b0;
    pulse_start(2);
    for (int k = 0; k < 20 && !hit; k++) begin
      if (m_read2 && m_address2) hit = 1'b1;
      @(posedge clock); #1;
    end
    n_cmp++; if (!hit || busy2 !== 1'b1) begin n_err++; $display("FAIL rmid_reach: got busy %b want 1", busy2); end
    #2 reset_n = 1'b0; #1;
    n_cmp++; if ({m_read2, m_address2, busy2, done2, id_ok2, ts_ok2, mis2, cid2, cts2} !== '0) begin
      n_err++; $display("FAIL rmid_async: got %h want 0", {m_read2, m_address2, busy2, done2, id_ok2, ts_ok2, mis2, cid2, cts2}); end
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    run_to_done(2, len, tsr, to);
    n_cmp++; if (to || len != 7) begin n_err++; $display("FAIL rmid_len: got %0d want 7", len); end
    n_cmp++; if ({id_ok2, ts_ok2, mis2} !== 3'b110) begin n_err++; $display("FAIL rmid_flags: got %b want 110", {id_ok2, ts_ok2, mis2}); end
    repeat (10) @(posedge clock);
  endtask

  task automatic test_random();
    int len, tsr, s0, stalls; bit to;
    logic [2:0] exp_f;
    wr_mode = 2;
    for (int i = 0; i < 16; i++) begin
      id0_val = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
      ts0_val = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
      exp_f = {id0_val == EXP_ID, ts0_val == EXP_TS, !(id0_val == EXP_ID && ts0_val == EXP_TS)};
      s0 = stall_cnt0;
      pulse_start(0);
      run_to_done(0, len, tsr, to);
      stalls = stall_cnt0 - s0;
      n_cmp++; if (to || len != 3 + stalls) begin n_err++; $display("FAIL rnd_len[%0d]: got %0d want %0d", i, len, 3 + stalls); end
      n_cmp++; if ({id_ok0, ts_ok0, mis0} !== exp_f) begin n_err++; $display("FAIL rnd_flags[%0d]: got %b want %b", i, {id_ok0, ts_ok0, mis0}, exp_f); end
      n_cmp++; if (cid0 !== id0_val || cts0 !== ts0_val) begin
        n_err++; $display("FAIL rnd_cap[%0d]: got %h/%h want %h/%h", i, cid0, cts0, id0_val, ts0_val); end
    end
    wr_mode = 0;
    id0_val = EXP_ID; ts0_val = EXP_TS;
  endtask

  initial begin
    test_reset();
    test_auto_start();
    test_mismatch_id();
    test_stall();
    test_latency2();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
